// File: rtl/sm4_key_schedule.sv
// SM4 key-expansion engine. Whitens the master key with FK, runs KPC chained
// key-schedule rounds per clock, streams each beat of round keys out, stores
// all 32 round keys in a bank and serves them through an enc/dec ordered read port.
//
// Handshake: a master key is taken on any rising edge where key_valid and
// key_ready are both high; key_valid while key_ready is low is dropped, never
// queued. rk_out_valid is a one-cycle qualifier for rk_out/rk_out_idx with no
// back-pressure.
module sm4_key_schedule #(
  parameter int KPC    = 1,
  parameter int RD_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key_in,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [32*KPC-1:0] rk_out,
  output logic              rk_out_valid,
  output logic [4:0]        rk_out_idx,
  output logic              done,
  output logic              keys_ready,
  input  logic [4:0]        rd_addr,
  input  logic              rd_dec,
  output logic [31:0]       rd_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  // Index of the first round of the final beat.
  localparam logic [4:0] LAST = 5'(32 - KPC);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // CK_i byte j (j = 0 is the MSB) = (4i+j)*7 mod 256; the 8-bit arithmetic
  // does the modulo for free.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] w;
    logic [7:0]  base;
    logic [7:0]  b;
    w    = '0;
    base = {1'b0, i, 2'b00};
    for (int j = 0; j < 4; j++) begin
      b = (base + 8'(j)) * 8'd7;
      w[31-8*j -: 8] = b;
    end
    return w;
  endfunction

  // Byte-wise S-box substitution.
  function automatic logic [31:0] tau(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Key-schedule linear transform L' = B ^ (B<<<13) ^ (B<<<23).
  function automatic logic [31:0] lin_l(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  state_e              state_q, state_d;
  logic [4:0]          ctr_q, ctr_d;
  logic [31:0]         k_q [4];
  logic [31:0]         k_d [4];
  logic [31:0]         win_next [4];
  logic [31:0]         bank_q [32];
  logic [31:0]         bank_d [32];
  logic [32*KPC-1:0]   rk_cat;
  logic [32*KPC-1:0]   rk_out_q, rk_out_d;
  logic                rk_out_valid_q, rk_out_valid_d;
  logic [4:0]          rk_out_idx_q, rk_out_idx_d;
  logic                done_q, done_d;
  logic                keys_ready_q, keys_ready_d;
  logic [4:0]          rd_sel;
  logic [31:0]         rd_data_d;

  // KPC chained rounds from the current K window; lane j holds rk[ctr+j].
  always_comb begin : round_chain
    logic [31:0] e [KPC+4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) e[i] = k_q[i];
    for (int i = 4; i < KPC + 4; i++) e[i] = '0;
    rk_cat = '0;
    t      = '0;
    for (int j = 0; j < KPC; j++) begin
      t        = e[j+1] ^ e[j+2] ^ e[j+3] ^ ck_word(ctr_q + 5'(j));
      e[j+4]   = e[j] ^ lin_l(tau(t));
      rk_cat[32*j +: 32] = e[j+4];
    end
    for (int i = 0; i < 4; i++) win_next[i] = e[i+KPC];
  end

  // Next-state logic: key accept, per-beat bank write and window shift, completion.
  always_comb begin
    state_d        = state_q;
    ctr_d          = ctr_q;
    k_d            = k_q;
    bank_d         = bank_q;
    rk_out_d       = rk_out_q;
    rk_out_valid_d = 1'b0;
    rk_out_idx_d   = rk_out_idx_q;
    done_d         = 1'b0;
    keys_ready_d   = keys_ready_q;
    key_ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (key_valid) begin
          k_d[0]       = key_in[127:96] ^ FK0;
          k_d[1]       = key_in[95:64]  ^ FK1;
          k_d[2]       = key_in[63:32]  ^ FK2;
          k_d[3]       = key_in[31:0]   ^ FK3;
          ctr_d        = '0;
          keys_ready_d = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < KPC; j++) bank_d[ctr_q + 5'(j)] = rk_cat[32*j +: 32];
        k_d            = win_next;
        rk_out_d       = rk_cat;
        rk_out_valid_d = 1'b1;
        rk_out_idx_d   = ctr_q;
        // The counter is left alone on the final beat so it never passes 31;
        // the next accept is what clears it.
        if (ctr_q == LAST) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          keys_ready_d = 1'b1;
        end else begin
          ctr_d = ctr_q + 5'(KPC);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and streaming-output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ctr_q          <= '0;
      rk_out_q       <= '0;
      rk_out_valid_q <= 1'b0;
      rk_out_idx_q   <= '0;
      done_q         <= 1'b0;
      keys_ready_q   <= 1'b0;
      for (int i = 0; i < 4; i++) k_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      ctr_q          <= ctr_d;
      rk_out_q       <= rk_out_d;
      rk_out_valid_q <= rk_out_valid_d;
      rk_out_idx_q   <= rk_out_idx_d;
      done_q         <= done_d;
      keys_ready_q   <= keys_ready_d;
      k_q            <= k_d;
    end
  end

  // Key bank; left uninitialised because every read is gated by keys_ready.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  // Read select: decrypt order walks the bank from rk31 down.
  always_comb begin
    rd_sel    = rd_dec ? (5'd31 - rd_addr) : rd_addr;
    rd_data_d = keys_ready_q ? bank_q[rd_sel] : 32'h0;
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [31:0] rd_data_q;
      // Registered read port: one cycle from rd_addr/rd_dec to rd_data.
      always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
      end
      assign rd_data = rd_data_q;
    end else begin : g_rd_comb
      assign rd_data = rd_data_d;
    end
  endgenerate

  assign rk_out       = rk_out_q;
  assign rk_out_valid = rk_out_valid_q;
  assign rk_out_idx   = rk_out_idx_q;
  assign done         = done_q;
  assign keys_ready   = keys_ready_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Directed bench for sm4_key_schedule: three engines (KPC=1/2/4), stream
// scoreboard per engine, read-port, busy, rekey, reset and back-to-back steps.
module tb_sm4_key_schedule;

  localparam logic [127:0] STD_KEY  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] ALT_KEY  = 128'hDEADBEEF00112233445566778899AABB;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  localparam logic [7:0] SB [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [127:0] key_in = '0;
  logic [4:0]   rd_addr = '0;
  logic         rd_dec = 1'b0;
  logic         key_valid1 = 1'b0, key_valid2 = 1'b0, key_valid4 = 1'b0;
  logic         key_ready1, key_ready2, key_ready4;
  logic [31:0]  rk_out1;
  logic [63:0]  rk_out2;
  logic [127:0] rk_out4;
  logic         rk_out_valid1, rk_out_valid2, rk_out_valid4;
  logic [4:0]   rk_out_idx1, rk_out_idx2, rk_out_idx4;
  logic         done1, done2, done4;
  logic         keys_ready1, keys_ready2, keys_ready4;
  logic [31:0]  rd_data1, rd_data2, rd_data4;
  logic [1:0]   dbg_state1, dbg_state2, dbg_state4;

  sm4_key_schedule #(.KPC(1), .RD_REG(1)) u1 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid1), .key_ready(key_ready1),
    .rk_out(rk_out1), .rk_out_valid(rk_out_valid1), .rk_out_idx(rk_out_idx1), .done(done1),
    .keys_ready(keys_ready1), .rd_addr(rd_addr), .rd_dec(rd_dec), .rd_data(rd_data1),
    .dbg_state(dbg_state1));

  sm4_key_schedule #(.KPC(2), .RD_REG(1)) u2 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid2), .key_ready(key_ready2),
    .rk_out(rk_out2), .rk_out_valid(rk_out_valid2), .rk_out_idx(rk_out_idx2), .done(done2),
    .keys_ready(keys_ready2), .rd_addr(rd_addr), .rd_dec(rd_dec), .rd_data(rd_data2),
    .dbg_state(dbg_state2));

  sm4_key_schedule #(.KPC(4), .RD_REG(0)) u4 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid4), .key_ready(key_ready4),
    .rk_out(rk_out4), .rk_out_valid(rk_out_valid4), .rk_out_idx(rk_out_idx4), .done(done4),
    .keys_ready(keys_ready4), .rd_addr(rd_addr), .rd_dec(rd_dec), .rd_data(rd_data4),
    .dbg_state(dbg_state4));

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int done_cnt1 = 0;
  logic [36:0]  exp_q1[$];
  logic [68:0]  exp_q2[$];
  logic [132:0] exp_q4[$];

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_ck(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
    return w;
  endfunction

  function automatic logic [31:0] model_rk(input logic [127:0] mk, input int n);
    logic [31:0] k [36];
    logic [31:0] t, b;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 4; i < 36; i++) k[i] = '0;
    for (int i = 0; i <= n; i++) begin
      t = k[i+1] ^ k[i+2] ^ k[i+3] ^ model_ck(i);
      b = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]};
      k[i+4] = k[i] ^ b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
    end
    return k[n+4];
  endfunction

  // Push one full expansion's worth of expected beats for the engine with the given KPC.
  task automatic push_set(input int kpc, input logic [127:0] mk);
    for (int b = 0; b < 32 / kpc; b++) begin
      logic [127:0] lanes;
      lanes = '0;
      for (int j = 0; j < kpc; j++) lanes[32*j +: 32] = model_rk(mk, b * kpc + j);
      case (kpc)
        1:       exp_q1.push_back({5'(b * kpc), lanes[31:0]});
        2:       exp_q2.push_back({5'(b * kpc), lanes[63:0]});
        default: exp_q4.push_back({5'(b * kpc), lanes});
      endcase
    end
  endtask

  // ---------------- stream monitors (scoreboard pop side) ----------------
  always @(negedge clk) begin
    if (rk_out_valid1) begin
      if (exp_q1.size() == 0) check("u1_beat_unexpected", 136'(exp_q1.size()), 136'd1);
      else check("u1_beat", {rk_out_idx1, rk_out1}, exp_q1.pop_front());
    end
    if (rk_out_valid2) begin
      if (exp_q2.size() == 0) check("u2_beat_unexpected", 136'(exp_q2.size()), 136'd1);
      else check("u2_beat", {rk_out_idx2, rk_out2}, exp_q2.pop_front());
    end
    if (rk_out_valid4) begin
      if (exp_q4.size() == 0) check("u4_beat_unexpected", 136'(exp_q4.size()), 136'd1);
      else check("u4_beat", {rk_out_idx4, rk_out4}, exp_q4.pop_front());
    end
    if (done1) done_cnt1++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a key to u1 and take it on the next edge.
  task automatic accept1(input logic [127:0] mk);
    key_in = mk;
    key_valid1 = 1'b1;
    check("u1_key_ready_before_accept", key_ready1, 1'b1);
    push_set(1, mk);
    tick();
    key_valid1 = 1'b0;
    check("u1_state_run", dbg_state1, 2'd1);
  endtask

  // Tick until u1 shows done, counting cycles from 'start'; bounded.
  task automatic wait_done1(input int start, output int n);
    bit seen;
    seen = 1'b0;
    n = start;
    while (!seen && n < start + 100) begin
      tick();
      n++;
      if (done1) seen = 1'b1;
    end
  endtask

  // ---------------- directed sequence ----------------
  int n, n2, n4;

  initial begin
    // Reset state.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", dbg_state1, 2'd0);
    check("rst_key_ready", key_ready1, 1'b1);
    check("rst_keys_ready", keys_ready1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_rk_valid", rk_out_valid1, 1'b0);
    check("rst_rk_out", rk_out4, 128'h0);
    check("rst_rd_data", rd_data1, 32'h0);

    // Standard vector on KPC=1, with a second key offered at cycle 5 of RUN.
    accept1(STD_KEY);
    check("u1_rk0_const", rk_out1, 32'h0);
    tick();
    check("u1_first_beat_rk0", rk_out1, 32'hF12186F9);
    tick(); tick(); tick();
    key_in = ALT_KEY;
    key_valid1 = 1'b1;
    tick();
    check("u1_busy_key_ready", key_ready1, 1'b0);
    key_valid1 = 1'b0;
    key_in = STD_KEY;
    wait_done1(5, n);
    check("u1_done_latency", n, 32);
    check("u1_keys_ready", keys_ready1, 1'b1);
    check("u1_state_done", dbg_state1, 2'd2);
    tick();
    check("u1_done_pulse", done1, 1'b0);

    // Read port, registered.
    rd_addr = 5'd0; rd_dec = 1'b0; tick();
    check("rd_enc_0", rd_data1, 32'hF12186F9);
    rd_addr = 5'd0; rd_dec = 1'b1; tick();
    check("rd_dec_0", rd_data1, 32'h9124A012);
    rd_addr = 5'd31; rd_dec = 1'b1; tick();
    check("rd_dec_31", rd_data1, 32'hF12186F9);
    rd_addr = 5'd3; rd_dec = 1'b0; tick();
    check("rd_enc_3", rd_data1, 32'h7BA92077);

    // Rekey in DONE with the all-zero key while reading rk0.
    rd_addr = 5'd0; rd_dec = 1'b0;
    key_in = ZERO_KEY;
    key_valid1 = 1'b1;
    push_set(1, ZERO_KEY);
    tick();
    key_valid1 = 1'b0;
    check("rekey_read_old", rd_data1, 32'hF12186F9);
    check("rekey_keys_ready_drop", keys_ready1, 1'b0);
    n = 0;
    while (!done1 && n < 100) begin
      tick();
      n++;
      check("rekey_rd_zero", rd_data1, 32'h0);
    end
    check("rekey_done_latency", n, 32);
    tick();
    check("rekey_new_rk0", rd_data1, model_rk(ZERO_KEY, 0));

    // Standard vector on KPC=2 and KPC=4 together.
    key_in = STD_KEY;
    key_valid2 = 1'b1;
    key_valid4 = 1'b1;
    push_set(2, STD_KEY);
    push_set(4, STD_KEY);
    tick();
    key_valid2 = 1'b0;
    key_valid4 = 1'b0;
    tick();
    check("u4_first_beat", {rk_out_idx4, rk_out4},
          {5'd0, 128'h7BA920775A6AB19A41662B61F12186F9});
    n2 = 0; n4 = 0;
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (done2 && n2 == 0) n2 = c;
      if (done4 && n4 == 0) n4 = c;
    end
    check("u2_done_latency", n2, 16);
    check("u4_done_latency", n4, 8);
    check("u2_keys_ready", keys_ready2, 1'b1);
    check("u4_keys_ready", keys_ready4, 1'b1);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      rd_dec = a[0];
      #1;
      check("u4_bank_comb", rd_data4, model_rk(STD_KEY, a[0] ? 31 - a : a));
      tick();
      check("u2_bank_reg", rd_data2, model_rk(STD_KEY, a[0] ? 31 - a : a));
    end

    // Reset in the middle of RUN.
    accept1(STD_KEY);
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q1.delete();
    check("midrst_state", dbg_state1, 2'd0);
    check("midrst_key_ready", key_ready1, 1'b1);
    check("midrst_rk_valid", rk_out_valid1, 1'b0);
    check("midrst_keys_ready", keys_ready1, 1'b0);
    check("midrst_done", done1, 1'b0);
    check("midrst_rk_idx", rk_out_idx1, 5'd0);
    n = done_cnt1;
    for (int c = 0; c < 40; c++) tick();
    check("midrst_no_done", done_cnt1, n);
    accept1(STD_KEY);
    wait_done1(0, n);
    check("reload_done_latency", n, 32);
    rd_addr = 5'd0; rd_dec = 1'b1; tick();
    check("reload_rk31", rd_data1, 32'h9124A012);

    // Back-to-back: key_valid held high across two expansions.
    key_in = STD_KEY;
    key_valid1 = 1'b1;
    push_set(1, STD_KEY);
    push_set(1, ALT_KEY);
    tick();
    key_in = ALT_KEY;
    wait_done1(0, n);
    check("b2b_first_done", n, 32);
    wait_done1(0, n);
    key_valid1 = 1'b0;
    check("b2b_done_spacing", n, 33);
    tick();
    check("b2b_settled_state", dbg_state1, 2'd2);
    rd_addr = 5'd5; rd_dec = 1'b0; tick();
    check("b2b_second_set", rd_data1, model_rk(ALT_KEY, 5));

    // Everything that was expected must have arrived.
    tick(); tick();
    check("q1_drained", exp_q1.size(), 0);
    check("q2_drained", exp_q2.size(), 0);
    check("q4_drained", exp_q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm4_key_schedule.md
Name: sm4_key_schedule

Overview:
- Sequential SM4 key-expansion engine. Accepts a 128-bit master key, applies the FK whitening, and iterates the key-schedule round function to produce the 32 round keys rk0..rk31.
- Generates KPC keys per clock, streams them out as they are produced, and stores all 32 in an internal bank.
- Serves the SM4 data-path cores through a random-access read port with an encrypt/decrypt ordering mode.

Parameters:
- KPC, 1, round keys generated per clock. Legal values are 1, 2, 4; expansion takes 32/KPC cycles.
- RD_REG, 1, read-port latency in cycles: 1 = registered, 0 = combinational.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  master key MK0..MK3; MK0 = key_in[127:96].
- key_valid  input  1  master key offered.
- key_ready  output  1  engine can accept a key. High in IDLE and DONE.
- rk_out  output  32*KPC  keys generated this cycle. Lane j (bits 32j+31:32j) carries rk[n+j].
- rk_out_valid  output  1  rk_out valid.
- rk_out_idx  output  5  index n of lane 0.
- done  output  1  one-cycle pulse when all 32 keys are stored.
- keys_ready  output  1  the bank holds a complete, consistent key set.
- rd_addr  input  5  round number to read.
- rd_dec  input  1  0 = encrypt order (rk[rd_addr]); 1 = decrypt order (rk[31-rd_addr]).
- rd_data  output  32  selected round key. Reads 0 while keys_ready = 0.

Behaviour:
- States:
  - IDLE: after reset; no valid keys.
  - RUN: expansion in progress.
  - DONE: keys valid.
- Accept condition: key_valid && key_ready at a rising edge.
  - Loads K0..K3 = MK0^A3B1BAC6, MK1^56AA3350, MK2^677D9197, MK3^B27022DC.
  - Clears the counter to 0, clears keys_ready, and moves to RUN.
- Each RUN cycle computes KPC chained rounds combinationally. For round i:
  - T = K(i+1) ^ K(i+2) ^ K(i+3) ^ CK_i.
  - Apply the SM4 S-box to each of the four bytes of T to get B.
  - L' = B ^ (B<<<13) ^ (B<<<23).
  - rk[i] = K(i) ^ L'.
- CK_i, byte j (j = 0 is the MSB) = (4i+j)*7 mod 256. Generated from the round index; no lookup ROM over 32 entries is required.
- At the end of each RUN cycle:
  - Write rk[n..n+KPC-1] to the bank.
  - Shift the K window by KPC.
  - Advance the counter by KPC.
  - Drive rk_out, rk_out_valid = 1, rk_out_idx = n as registered outputs, visible the cycle after the edge that computed them.
- Latency: the accept edge is edge 0. The final write occurs at edge 32/KPC; done = 1 and keys_ready = 1 are visible during the cycle that follows. The state is then DONE.
  - KPC=1: 32 cycles.
  - KPC=2: 16 cycles.
  - KPC=4: 8 cycles.
- key_ready = 0 throughout RUN. key_valid in RUN is ignored, not queued.
- Rekey from DONE:
  - Accept is allowed; keys_ready drops at the accept edge.
  - Bank contents are overwritten progressively.
  - rd_data reads 0 until the new done.
- rd_data:
  - RD_REG=1: registered; reflects rd_addr/rd_dec and keys_ready sampled at the previous edge.
  - RD_REG=0: combinational.
- Reset:
  - Synchronous; overrides everything, including mid-RUN.
  - State = IDLE; key_ready = 1; keys_ready, done, rk_out_valid = 0; rk_out, rk_out_idx, rd_data = 0.
  - The bank need not be cleared, because reads are gated by keys_ready.
- Simultaneous accept with a rd_addr read in DONE: the read in that cycle returns the old key, since keys_ready was still 1 when sampled. The next read returns 0.
- The counter wraps only through the state change. It never exceeds 31 and never writes past rk31.

Test Plan:
- Standard vector, KPC=1. key_in = 0123456789ABCDEFFEDCBA9876543210.
  - Required: rk_out stream rk0=F12186F9, rk1=41662B61, rk2=5A6AB19A, rk3=7BA92077 … rk31=9124A012.
  - done visible exactly 32 cycles after the accept edge; keys_ready = 1.
- Same vector with KPC=2 and KPC=4.
  - Required: identical bank contents; done after 16 and 8 cycles respectively.
  - KPC=4 first beat: rk_out = {7BA92077,5A6AB19A,41662B61,F12186F9}, rk_out_idx = 0.
- Read port in DONE, RD_REG=1.
  - rd_addr=0, rd_dec=0 -> F12186F9 one cycle later.
  - rd_addr=0, rd_dec=1 -> 9124A012.
  - rd_addr=31, rd_dec=1 -> F12186F9.
- Busy handling.
  - Assert key_valid with a second key at cycle 5 of RUN: ignored, key_ready = 0, results unchanged.
  - Rekey in DONE with all-zero key: keys_ready drops and rd_data = 0 until the new done. The new set has rk0 ≠ F12186F9.
- Reset mid-RUN at cycle 10.
  - Required: next cycle state = IDLE, key_ready = 1, rk_out_valid = 0, keys_ready = 0, no done pulse.
  - A subsequent standard-vector load reproduces rk0..rk31 exactly.
- Back-to-back: key_valid held high continuously.
  - Required: re-acceptance in the cycle done is visible; two full correct expansions; done pulses exactly 32/KPC + 1 cycles apart.
